// File: rtl/systolic_pe.sv
// Systolic-array processing element: forwards activations/weights and MACs them.
// Optional build macro SYSTOLIC_PE_SAT_EN makes ACC-mode additions saturate.
module systolic_pe #(
    parameter int A_W    = 8,
    parameter int W_W    = 8,
    parameter int ACC_W  = 24,
    parameter int SIGNED = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode,
    input  logic [A_W-1:0]   a_in,
    input  logic             a_valid_in,
    input  logic [W_W-1:0]   w_in,
    input  logic [ACC_W-1:0] sum_in,
    input  logic             clear,
    input  logic             drain,
    output logic [A_W-1:0]   a_out,
    output logic [W_W-1:0]   w_out,
    output logic             a_valid_out,
    output logic             drain_out,
    output logic [ACC_W-1:0] sum_out,
    output logic             sum_valid_out,
    output logic             sat_flag
);

    localparam int P_W = A_W + W_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [A_W-1:0]   a_q, a_d;
    logic [W_W-1:0]   w_q, w_d;
    logic             av_q, av_d;
    logic             dr_q, dr_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] sum_q, sum_d;
    logic             sv_q, sv_d;
    logic             sat_q, sat_d;

    logic signed [P_W-1:0] a_s, w_s;
    logic [P_W-1:0]        prod_raw;
    logic [ACC_W-1:0]      prod;
    logic [ACC_W:0]        add_run;
    logic [ACC_W:0]        add_drn;

    // Returns {overflow, result}; result clamps only in the saturating build.
    function automatic logic [ACC_W:0] add_acc(
        input logic [ACC_W-1:0] x,
        input logic [ACC_W-1:0] y
    );
        logic [ACC_W:0]   s;
        logic [ACC_W-1:0] r;
        logic             ovf;
`ifdef SYSTOLIC_PE_SAT_EN
        s   = {1'b0, x} + {1'b0, y};
        r   = s[ACC_W-1:0];
        ovf = 1'b0;
        if (SIGNED != 0) begin
            if ((x[ACC_W-1] == y[ACC_W-1]) && (r[ACC_W-1] != x[ACC_W-1])) begin
                ovf = 1'b1;
                r   = x[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                 : {1'b0, {(ACC_W-1){1'b1}}};
            end
        end else if (s[ACC_W]) begin
            ovf = 1'b1;
            r   = '1;
        end
`else
        s   = '0;
        r   = x + y;
        ovf = s[0];
`endif
        return {ovf, r};
    endfunction

    // Product of the registered operands, extended to accumulator width.
    always_comb begin
        if (SIGNED != 0) begin
            a_s  = P_W'($signed(a_q));
            w_s  = P_W'($signed(w_q));
            prod_raw = a_s * w_s;
            prod = ACC_W'($signed(prod_raw));
        end else begin
            a_s  = P_W'(a_q);
            w_s  = P_W'(w_q);
            prod_raw = a_s * w_s;
            prod = ACC_W'(prod_raw);
        end
    end

    // Next-state, accumulator and output computation.
    always_comb begin
        a_d     = a_in;
        w_d     = w_in;
        av_d    = a_valid_in;
        dr_d    = drain;
        state_d = state_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        sv_d    = 1'b0;
        sat_d   = sat_q;
        add_run = add_acc(acc_q, prod);
        add_drn = add_acc(acc_q, av_q ? prod : '0);
        unique case (state_q)
            IDLE: begin
                acc_d = '0;
                if (!mode) begin
                    sum_d = sum_in + prod;
                    sv_d  = av_q;
                end else if (av_q) begin
                    acc_d   = prod;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (clear) begin
                    acc_d   = '0;
                    sat_d   = 1'b0;
                    state_d = IDLE;
                end else if (drain) begin
                    sum_d   = add_drn[ACC_W-1:0];
                    sv_d    = 1'b1;
                    sat_d   = sat_q | add_drn[ACC_W];
                    state_d = DRAIN;
                end else if (av_q) begin
                    acc_d = add_run[ACC_W-1:0];
                    sat_d = sat_q | add_run[ACC_W];
                end
            end
            DRAIN: begin
                sat_d = 1'b0;
                if (clear) begin
                    acc_d   = '0;
                    state_d = IDLE;
                end else begin
                    acc_d   = av_q ? prod : '0;
                    state_d = av_q ? ACCUM : IDLE;
                end
            end
            default: begin
                acc_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // State and pipeline registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            w_q     <= '0;
            av_q    <= 1'b0;
            dr_q    <= 1'b0;
            acc_q   <= '0;
            sum_q   <= '0;
            sv_q    <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            w_q     <= w_d;
            av_q    <= av_d;
            dr_q    <= dr_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            sv_q    <= sv_d;
            sat_q   <= sat_d;
        end
    end

    assign a_out         = a_q;
    assign w_out         = w_q;
    assign a_valid_out   = av_q;
    assign drain_out     = dr_q;
    assign sum_out       = sum_q;
    assign sum_valid_out = sv_q;
    assign sat_flag      = sat_q;

endmodule

// File: tb/tb_systolic_pe.sv
// Bench for systolic_pe: directed scenarios plus random traffic
// against a transaction-level accumulate/drain model.
module tb_systolic_pe;

    localparam longint MAX0 = (64'd1 << 24) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // unsigned instance (defaults)
    logic        mode0, av0, clr0, dr0;
    logic [7:0]  a0, w0;
    logic [23:0] s0;
    logic [7:0]  a_out0, w_out0;
    logic        avo0, dro0, sv0, sat0;
    logic [23:0] sum0;

    // signed 16-bit instance
    logic        mode1, av1, clr1, dr1;
    logic [7:0]  a1, w1;
    logic [15:0] s1;
    logic [7:0]  a_out1, w_out1;
    logic        avo1, dro1, sv1, sat1;
    logic [15:0] sum1;

    systolic_pe u0 (
        .clk(clk), .rst(rst), .mode(mode0), .a_in(a0),
        .a_valid_in(av0), .w_in(w0), .sum_in(s0), .clear(clr0),
        .drain(dr0), .a_out(a_out0), .w_out(w_out0),
        .a_valid_out(avo0), .drain_out(dro0), .sum_out(sum0),
        .sum_valid_out(sv0), .sat_flag(sat0)
    );

    systolic_pe #(.A_W(8), .W_W(8), .ACC_W(16), .SIGNED(1)) u1 (
        .clk(clk), .rst(rst), .mode(mode1), .a_in(a1),
        .a_valid_in(av1), .w_in(w1), .sum_in(s1), .clear(clr1),
        .drain(dr1), .a_out(a_out1), .w_out(w_out1),
        .a_valid_out(avo1), .drain_out(dro1), .sum_out(sum1),
        .sum_valid_out(sv1), .sat_flag(sat1)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // model of u0
    longint m_a, m_w, m_total, m_sum;
    bit     m_v, m_dr, m_open, m_just, m_sv, m_sat, ovf0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic longint fit0(input longint x);
`ifdef SYSTOLIC_PE_SAT_EN
        if (x > MAX0) begin
            ovf0 = 1'b1;
            return MAX0;
        end
        return x;
`else
        return x & MAX0;
`endif
    endfunction

    // advance model and DUTs one cycle, then check u0 against model
    task automatic tick();
        longint prod;
        prod = m_a * m_w;
        ovf0 = 1'b0;
        if (rst) begin
            m_a = 0; m_w = 0; m_v = 0; m_dr = 0;
            m_total = 0; m_sum = 0; m_open = 0;
            m_just = 0; m_sv = 0; m_sat = 0;
        end else begin
            m_sv = 1'b0;
            if (m_just) begin
                m_just = 1'b0;
                m_sat  = 1'b0;
                if (clr0) m_open = 1'b0;
                else begin
                    m_open  = m_v;
                    m_total = m_v ? prod : 0;
                end
            end else if (!m_open) begin
                if (!mode0) begin
                    m_sum = (longint'(s0) + prod) & MAX0;
                    m_sv  = m_v;
                end else if (m_v) begin
                    m_open  = 1'b1;
                    m_total = prod;
                end
            end else if (clr0) begin
                m_open = 1'b0;
                m_sat  = 1'b0;
            end else if (dr0) begin
                m_sum  = fit0(m_total + (m_v ? prod : 0));
                m_sv   = 1'b1;
                m_just = 1'b1;
                m_open = 1'b0;
                m_sat  = m_sat | ovf0;
            end else if (m_v) begin
                m_total = fit0(m_total + prod);
                m_sat   = m_sat | ovf0;
            end
            m_a = a0; m_w = w0; m_v = av0; m_dr = dr0;
        end
        @(posedge clk);
        #1;
        chk("a_out", a_out0, m_a);
        chk("w_out", w_out0, m_w);
        chk("a_valid_out", avo0, m_v);
        chk("drain_out", dro0, m_dr);
        chk("sum_out", sum0, m_sum);
        chk("sum_valid_out", sv0, m_sv);
        chk("sat_flag", sat0, m_sat);
    endtask

    initial begin
        rst = 1'b1;
        mode0 = 0; av0 = 0; clr0 = 0; dr0 = 0; a0 = 0; w0 = 0; s0 = 0;
        mode1 = 1; av1 = 0; clr1 = 0; dr1 = 0; a1 = 0; w1 = 0; s1 = 0;
        m_a = 0; m_w = 0; m_v = 0; m_dr = 0; m_total = 0; m_sum = 0;
        m_open = 0; m_just = 0; m_sv = 0; m_sat = 0; ovf0 = 0;
        tick();
        chk("rst_sum0", sum0, 0);
        chk("rst_sum1", sum1, 0);
        chk("rst_sat1", sat1, 0);
        rst = 1'b0;

        // signed accumulation of (-128,-128) x3, drained with the third
        a1 = 8'h80; w1 = 8'h80; av1 = 1;
        tick(); tick(); tick();
        av1 = 0; dr1 = 1;
        tick();
`ifdef SYSTOLIC_PE_SAT_EN
        chk("sgn_sat_sum", sum1, 16'h7FFF);
        chk("sgn_sat_flag", sat1, 1);
`else
        chk("sgn_wrap_sum", sum1, 16'hC000);
        chk("sgn_wrap_flag", sat1, 0);
`endif
        chk("sgn_sv", sv1, 1);
        dr1 = 0; mode1 = 0;
        tick();
        chk("sgn_sv_end", sv1, 0);

        // PASS: 3*5 + 10
        a0 = 3; w0 = 5; av0 = 1;
        tick();
        a0 = 0; w0 = 0; av0 = 0; s0 = 10;
        tick();
        chk("pass_sum", sum0, 25);
        chk("pass_sv", sv0, 1);
        s0 = 0;

        // ACC: (2,3),(4,5),(1,1) drained with the last
        mode0 = 1;
        a0 = 2; w0 = 3; av0 = 1; tick();
        a0 = 4; w0 = 5; tick();
        a0 = 1; w0 = 1; tick();
        av0 = 0; dr0 = 1; tick();
        chk("acc_sum27", sum0, 27);
        chk("acc_sv27", sv0, 1);
        dr0 = 0; tick();
        chk("acc_pulse_end", sv0, 0);
        chk("acc_hold27", sum0, 27);

        // drain coincident with valid (6,7) after acc=10
        a0 = 2; w0 = 5; av0 = 1; tick();
        av0 = 0; tick();
        a0 = 6; w0 = 7; av0 = 1; tick();
        dr0 = 1; a0 = 1; w0 = 2; tick();
        chk("drain_valid52", sum0, 52);
        dr0 = 0; a0 = 3; w0 = 3; tick();
        av0 = 0; tick();
        dr0 = 1; tick();
        chk("restart11", sum0, 11);
        dr0 = 0; tick();

        // clear with drain at acc=100
        a0 = 10; w0 = 10; av0 = 1; tick();
        av0 = 0; tick();
        clr0 = 1; dr0 = 1; tick();
        chk("clr_drain_sv", sv0, 0);
        clr0 = 0; tick();
        tick();
        chk("idle_drain_sv", sv0, 0);
        dr0 = 0;
        a0 = 1; w0 = 1; av0 = 1; tick();
        av0 = 0; tick();
        dr0 = 1; tick();
        chk("after_clear1", sum0, 1);
        dr0 = 0; tick();

        // reset mid-accumulation
        a0 = 5; w0 = 10; av0 = 1; tick();
        av0 = 0; tick();
        rst = 1; tick();
        chk("rst_mid_sum", sum0, 0);
        chk("rst_mid_sv", sv0, 0);
        chk("rst_mid_avo", avo0, 0);
        rst = 0; dr0 = 1; tick(); tick();
        chk("rst_mid_nodrain", sv0, 0);
        dr0 = 0; tick();

        // random traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0) mode0 = ~mode0;
            a0   = 8'($urandom_range(0, 255));
            w0   = 8'($urandom_range(0, 255));
            av0  = ($urandom_range(0, 3) != 0);
            s0   = 24'($urandom);
            clr0 = ($urandom_range(0, 9) == 0);
            dr0  = ($urandom_range(0, 4) == 0);
            rst  = ($urandom_range(0, 99) == 0);
            tick();
        end
        rst = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/systolic_pe.md
SYSTOLIC_PE -- requirements
Module: systolic_pe

Interface
REQ-001 SHALL have parameter A_W, default 8, activation width in bits.
REQ-002 SHALL have parameter W_W, default 8, weight width in bits.
REQ-003 SHALL have parameter ACC_W, default 24, accumulator and partial-sum width; ACC_W >= A_W+W_W.
REQ-004 SHALL have parameter SIGNED, default 0; 0 selects unsigned operands, 1 selects two's-complement operands.
REQ-005 SHALL use one clock; reset is synchronous and active-high.
REQ-006 clk  in  1  clock; all state updates on rising edge.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 mode  in  1  0 = PASS (partial sum flows through), 1 = ACC (output-stationary local accumulation).
REQ-009 a_in  in  A_W  activation from west neighbour.
REQ-010 a_valid_in  in  1  a_in and w_in qualifier.
REQ-011 w_in  in  W_W  weight from north neighbour.
REQ-012 sum_in  in  ACC_W  partial sum from north neighbour (PASS only).
REQ-013 clear  in  1  discard accumulator (ACC only).
REQ-014 drain  in  1  emit accumulator (ACC only).
REQ-015 a_out  out  A_W  registered a_in to east neighbour.
REQ-016 w_out  out  W_W  registered w_in to south neighbour.
REQ-017 a_valid_out  out  1  registered a_valid_in.
REQ-018 drain_out  out  1  drain delayed one cycle, for daisy-chained drain.
REQ-019 sum_out  out  ACC_W  partial sum (PASS) or drained result (ACC).
REQ-020 sum_valid_out  out  1  sum_out qualifier.
REQ-021 sat_flag  out  1  sticky accumulator-saturation indicator.

Function
REQ-022 a_out, w_out, a_valid_out, drain_out SHALL equal the previous cycle's inputs (1-cycle latency), every cycle, independent of mode.
REQ-023 product SHALL be a_out*w_out at A_W+W_W bits, signed when SIGNED=1, then sign- (SIGNED=1) or zero-extended (SIGNED=0) to ACC_W.
REQ-024 PASS: each cycle sum_out <= sum_in + product (modulo 2^ACC_W) and sum_valid_out <= a_valid_out; accumulator unused.
REQ-025 FSM states IDLE, ACCUM, DRAIN; in PASS the FSM SHALL remain in IDLE.
REQ-026 IDLE, mode=1, a_valid_out=1: acc <= product, go to ACCUM; otherwise stay, acc=0.
REQ-027 ACCUM: clear=1 -> acc <= 0, go to IDLE, that cycle's product discarded; clear has priority over drain.
REQ-028 ACCUM: drain=1, clear=0 -> sum_out <= acc + (a_valid_out ? product : 0), sum_valid_out <= 1 for exactly one cycle, go to DRAIN.
REQ-029 ACCUM otherwise: acc <= acc + product when a_valid_out=1, else hold.
REQ-030 DRAIN (one cycle): acc <= a_valid_out ? product : 0; go to ACCUM if a_valid_out else IDLE; drain ignored, clear returns to IDLE with acc=0.
REQ-031 ACC: sum_valid_out SHALL be 0 except the drain cycle; sum_out holds last drained value; sum_in ignored.
REQ-032 mode SHALL be sampled only in IDLE; changes in ACCUM/DRAIN take effect after return to IDLE.
REQ-033 PASS: clear and drain ignored except drain_out propagation.

Reset
REQ-034 rst=1 SHALL force at the next edge: a_out=0, w_out=0, a_valid_out=0, drain_out=0, sum_out=0, sum_valid_out=0, sat_flag=0, acc=0, state=IDLE; mid-accumulation reset discards acc with no drain pulse.

Configuration
REQ-035 Macro SYSTOLIC_PE_SAT_EN defined: ACC-mode additions (REQ-026/028/029/030) SHALL saturate at the ACC_W max/min of the selected signedness and set sat_flag, sticky until clear, drain, or rst.
REQ-036 Macro undefined: additions wrap modulo 2^ACC_W; sat_flag tied 0; PASS always wraps in both builds.

Verification
REQ-037 PASS, SIGNED=0: a_in=3, w_in=5, valid; next cycle sum_in=10 -> following cycle sum_out=25, sum_valid_out=1.
REQ-038 ACC: valid (2,3),(4,5),(1,1) on consecutive cycles, drain with last -> sum_out=27, one-cycle sum_valid_out pulse, acc restarts.
REQ-039 ACC: drain in same cycle as new valid (6,7) after acc=10 -> sum_out=10+42=52; next valid (1,2) without gap -> next drain yields 2 plus subsequent products.
REQ-040 ACC: clear and drain together with acc=100 -> no sum_valid_out, state IDLE, acc=0.
REQ-041 SIGNED=1, SYSTOLIC_PE_SAT_EN, ACC_W=16, A_W=W_W=8: repeated (-128,-128) x3 -> sum_out=32767, sat_flag=1; without macro sum_out=-16384 (0xC000), sat_flag=0.
REQ-042 Assert rst during ACCUM with acc=50 -> all outputs 0 next cycle, later drain with no valid yields no pulse.
